// File: rtl/ac_motor_vector_sequencer.sv
// ac_motor_vector_sequencer: symmetric seven-segment SVPWM sequencer with per-phase dead time
// Ports: clk/reset (sync, active high), enable (run request), sector + t0/t1/t2/t7 (dwell times,
// snapshotted once per period), vector (active {a,b,c} state), period_start (first cycle of period),
// gate_high/gate_low (inverter gates per phase), fault_overrun/fault_sector (sticky faults).
module ac_motor_vector_sequencer #(
    parameter int PERIOD    = 20000,
    parameter int DEAD_TIME = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  sector,
    input  logic [14:0] t0,
    input  logic [14:0] t1,
    input  logic [14:0] t2,
    input  logic [14:0] t7,
    output logic [2:0]  vector,
    output logic        period_start,
    output logic [2:0]  gate_high,
    output logic [2:0]  gate_low,
    output logic        fault_overrun,
    output logic        fault_sector
);
    typedef enum logic [1:0] {IDLE, SNAP, CALC, RUN} state_t;
    state_t      state, nstate;
    logic [16:0] cnt;
    logic [2:0]  sec_q;
    logic [14:0] t0_q, t1_q, t2_q, t7_q;
    logic [16:0] bnd [8];
    logic [2:0]  seg_v [8];
    logic [16:0] nbnd [8];
    logic [2:0]  nseg [8];
    logic [2:0]  ks, va, vb, cur_v;
    logic [14:0] ta, tb, h0, ha, hb, h7;
    logic [7:0]  dt [3];
    logic [2:0]  dq;
    logic        snap, calc;

    // V1..V6 indexed from 0
    function automatic logic [2:0] vtab(input logic [2:0] i);
        case (i)
            3'd0:    vtab = 3'b100;
            3'd1:    vtab = 3'b110;
            3'd2:    vtab = 3'b010;
            3'd3:    vtab = 3'b011;
            3'd4:    vtab = 3'b001;
            default: vtab = 3'b101;
        endcase
    endfunction

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = enable ? SNAP : IDLE;
            SNAP:    nstate = CALC;
            CALC:    nstate = RUN;
            default: nstate = RUN;
        endcase
        if (!enable) nstate = IDLE;
    end

    assign snap = enable && (state == SNAP || (state == RUN && cnt == 17'(PERIOD - 2)));
    assign calc = enable && (state == CALC || (state == RUN && cnt == 17'(PERIOD - 1)));

    // Odd sectors swap the order of the two active vectors so only one phase changes per step
    always_comb begin
        ks = (sec_q > 3'd5) ? 3'd0 : sec_q;
        ta = ks[0] ? t2_q : t1_q;
        tb = ks[0] ? t1_q : t2_q;
        va = ks[0] ? vtab((ks == 3'd5) ? 3'd0 : ks + 3'd1) : vtab(ks);
        vb = ks[0] ? vtab(ks) : vtab((ks == 3'd5) ? 3'd0 : ks + 3'd1);
        h0 = t0_q >> 1;
        ha = ta >> 1;
        hb = tb >> 1;
        h7 = t7_q >> 1;
        nbnd[0] = 17'(h0);
        nbnd[1] = nbnd[0] + 17'(ha);
        nbnd[2] = nbnd[1] + 17'(hb);
        nbnd[3] = nbnd[2] + 17'(h7);
        nbnd[4] = nbnd[3] + 17'(t7_q - h7);
        nbnd[5] = nbnd[4] + 17'(tb - hb);
        nbnd[6] = nbnd[5] + 17'(ta - ha);
        nbnd[7] = nbnd[6] + 17'(t0_q - h0);
        nseg = '{3'b000, va, vb, 3'b111, 3'b111, vb, va, 3'b000};
    end

    // Lowest segment whose end boundary lies beyond the counter wins; past the end is 000
    always_comb begin
        cur_v = 3'b000;
        for (int i = 7; i >= 0; i--)
            if (cnt < bnd[i]) cur_v = seg_v[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nstate;
            cnt   <= (state == RUN && nstate == RUN && cnt != 17'(PERIOD - 1)) ? cnt + 17'd1 : 17'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q         <= '0;
            t0_q          <= '0;
            t1_q          <= '0;
            t2_q          <= '0;
            t7_q          <= '0;
            bnd           <= '{default: '0};
            seg_v         <= '{default: '0};
            fault_overrun <= 1'b0;
            fault_sector  <= 1'b0;
        end else begin
            if (snap) begin
                sec_q <= sector;
                t0_q  <= t0;
                t1_q  <= t1;
                t2_q  <= t2;
                t7_q  <= t7;
            end
            if (calc) begin
                bnd   <= nbnd;
                seg_v <= nseg;
                if (nbnd[7] > 17'(PERIOD)) fault_overrun <= 1'b1;
                if (sec_q > 3'd5) fault_sector <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state != RUN || nstate != RUN) begin
            vector       <= '0;
            period_start <= 1'b0;
        end else begin
            vector       <= cur_v;
            period_start <= (cnt == 17'd0);
        end
    end

    // Entering RUN starts every phase in dead time so the low sides wait DEAD_TIME before closing
    always_ff @(posedge clk) begin
        if (reset || nstate != RUN) begin
            gate_high <= '0;
            gate_low  <= '0;
            dq        <= '0;
            dt        <= '{default: '0};
        end else if (state != RUN) begin
            gate_high <= '0;
            gate_low  <= '0;
            dq        <= '0;
            dt        <= '{default: 8'(DEAD_TIME)};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (vector[i] != dq[i]) begin
                    dq[i]        <= vector[i];
                    dt[i]        <= 8'(DEAD_TIME);
                    gate_high[i] <= 1'b0;
                    gate_low[i]  <= 1'b0;
                end else if (dt[i] > 8'd1) begin
                    dt[i] <= dt[i] - 8'd1;
                end else begin
                    dt[i]        <= 8'd0;
                    gate_high[i] <= dq[i];
                    gate_low[i]  <= ~dq[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_ac_motor_vector_sequencer.sv
// tb_ac_motor_vector_sequencer: table-driven check of SVPWM sequence, faults, dead time and exit
module tb_ac_motor_vector_sequencer;
    localparam int P = 100;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  sector = '0;
    logic [14:0] t0 = '0, t1 = '0, t2 = '0, t7 = '0;
    logic [2:0]  vector, gate_high, gate_low;
    logic        period_start, fault_overrun, fault_sector;

    ac_motor_vector_sequencer #(.PERIOD(P), .DEAD_TIME(D)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sector(sector),
        .t0(t0), .t1(t1), .t2(t2), .t7(t7),
        .vector(vector), .period_start(period_start),
        .gate_high(gate_high), .gate_low(gate_low),
        .fault_overrun(fault_overrun), .fault_sector(fault_sector)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        sec;
        logic [14:0]       a0, a1, a2, a7;
        logic [0:7][2:0]   v;
        logic [0:7][7:0]   n;
        logic              ovr;
        logic              sfl;
    } vec_t;

    vec_t       tbl [9];
    logic [2:0] cv [100], cgh [100], cgl [100], ev [100];
    logic       cps [100];
    logic       ps_end;
    int         total = 0, bad = 0;

    function automatic vec_t mk(input logic [2:0] s, input int a, input int b, input int c, input int d,
                                input logic [23:0] v, input logic [63:0] n, input logic o, input logic f);
        vec_t r;
        r.sec = s; r.a0 = 15'(a); r.a1 = 15'(b); r.a2 = 15'(c); r.a7 = 15'(d);
        r.v = v; r.n = n; r.ovr = o; r.sfl = f;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t r);
        int w;
        reset = 1'b1; enable = 1'b0;
        repeat (2) @(negedge clk);
        sector = r.sec; t0 = r.a0; t1 = r.a1; t2 = r.a2; t7 = r.a7;
        reset = 1'b0; enable = 1'b1;
        w = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (period_start) begin
                w = i;
                break;
            end
        end
        chk("start_latency", w, 3);
        for (int k = 0; k < 100; k++) begin
            cv[k] = vector; cgh[k] = gate_high; cgl[k] = gate_low; cps[k] = period_start;
            @(negedge clk);
        end
        ps_end = period_start;
    endtask

    task automatic expand(input vec_t r);
        int p = 0;
        for (int k = 0; k < 100; k++) ev[k] = 3'b000;
        for (int s = 0; s < 8; s++)
            for (int j = 0; j < int'(r.n[s]); j++) begin
                if (p < 100) ev[p] = r.v[s];
                p++;
            end
    endtask

    initial begin
        int mism, fi, ovl, pse, w;
        tbl[0] = mk(0, 20, 30, 30, 20, {3'b000,3'b100,3'b110,3'b111,3'b111,3'b110,3'b100,3'b000},
                    {8'd10,8'd15,8'd15,8'd10,8'd10,8'd15,8'd15,8'd10}, 0, 0);
        tbl[1] = mk(1, 20, 40, 20, 20, {3'b000,3'b010,3'b110,3'b111,3'b111,3'b110,3'b010,3'b000},
                    {8'd10,8'd10,8'd20,8'd10,8'd10,8'd20,8'd10,8'd10}, 0, 0);
        tbl[2] = mk(2, 21, 31, 29, 19, {3'b000,3'b010,3'b011,3'b111,3'b111,3'b011,3'b010,3'b000},
                    {8'd10,8'd15,8'd14,8'd9,8'd10,8'd15,8'd16,8'd11}, 0, 0);
        tbl[3] = mk(0, 40, 60, 0, 0, {3'b000,3'b100,3'b110,3'b111,3'b111,3'b110,3'b100,3'b000},
                    {8'd20,8'd30,8'd0,8'd0,8'd0,8'd0,8'd30,8'd20}, 0, 0);
        tbl[4] = mk(3, 10, 30, 20, 30, {3'b000,3'b001,3'b011,3'b111,3'b111,3'b011,3'b001,3'b000},
                    {8'd5,8'd10,8'd15,8'd15,8'd15,8'd15,8'd10,8'd5}, 0, 0);
        tbl[5] = mk(4, 20, 30, 30, 30, {3'b000,3'b001,3'b101,3'b111,3'b111,3'b101,3'b001,3'b000},
                    {8'd10,8'd15,8'd15,8'd15,8'd15,8'd15,8'd15,8'd10}, 1, 0);
        tbl[6] = mk(7, 20, 30, 30, 20, {3'b000,3'b100,3'b110,3'b111,3'b111,3'b110,3'b100,3'b000},
                    {8'd10,8'd15,8'd15,8'd10,8'd10,8'd15,8'd15,8'd10}, 0, 1);
        tbl[7] = mk(5, 10, 40, 20, 30, {3'b000,3'b100,3'b101,3'b111,3'b111,3'b101,3'b100,3'b000},
                    {8'd5,8'd10,8'd20,8'd15,8'd15,8'd20,8'd10,8'd5}, 0, 0);
        tbl[8] = mk(0, 20, 78, 2, 0, {3'b000,3'b100,3'b110,3'b111,3'b111,3'b110,3'b100,3'b000},
                    {8'd10,8'd39,8'd1,8'd0,8'd0,8'd1,8'd39,8'd10}, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset_vector", vector, 0);
        chk("reset_period_start", period_start, 0);
        chk("reset_gates", {gate_high, gate_low}, 0);
        chk("reset_faults", {fault_overrun, fault_sector}, 0);

        for (int i = 0; i < 9; i++) begin
            run(tbl[i]);
            expand(tbl[i]);
            mism = 0; fi = -1; ovl = 0; pse = 0;
            for (int k = 0; k < 100; k++) begin
                if (cv[k] !== ev[k]) begin
                    if (fi < 0) fi = k;
                    mism++;
                end
                if ((cgh[k] & cgl[k]) != 3'b000) ovl++;
                if (cps[k] !== (k == 0)) pse++;
            end
            if (fi >= 0) $display("case %0d first vector difference at cycle %0d: got %b expected %b", i, fi, cv[fi], ev[fi]);
            chk($sformatf("pattern_case%0d", i), mism, 0);
            chk($sformatf("period_case%0d", i), {pse[30:0], ps_end}, 1);
            chk($sformatf("gate_overlap_case%0d", i), ovl, 0);
            chk($sformatf("fault_overrun_case%0d", i), fault_overrun, tbl[i].ovr);
            chk($sformatf("fault_sector_case%0d", i), fault_sector, tbl[i].sfl);
        end

        // Entry dead time and phase a (bit 2) rising at cycle 10
        run(tbl[0]);
        chk("entry_low_off", cgl[1], 3'b000);
        chk("entry_low_on", cgl[2], 3'b111);
        chk("a_low_before", {cgh[10][2], cgl[10][2]}, 2'b01);
        chk("a_dead_start", {cgh[11][2], cgl[11][2]}, 2'b00);
        chk("a_dead_end", {cgh[13][2], cgl[13][2]}, 2'b00);
        chk("a_high_rise", {cgh[14][2], cgl[14][2]}, 2'b10);

        // Leaving RUN on enable low, then re-entry latency from IDLE
        enable = 1'b0;
        @(negedge clk);
        chk("exit_outputs", {vector, gate_high, gate_low, period_start}, 0);
        enable = 1'b1;
        w = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (period_start) begin
                w = i;
                break;
            end
        end
        chk("reentry_latency", w, 3);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset_outputs", {vector, gate_high, gate_low, period_start}, 0);

        // Phase b toggles 0->1 at 49 and back at 51: dead time reloads
        run(tbl[8]);
        chk("b_dead_first", {cgh[50][1], cgl[50][1]}, 2'b00);
        chk("b_reload_53", {cgh[53][1], cgl[53][1]}, 2'b00);
        chk("b_reload_54", {cgh[54][1], cgl[54][1]}, 2'b00);
        chk("b_low_rise", {cgh[55][1], cgl[55][1]}, 2'b01);

        // Faults persist past exit and clear on reset
        run(tbl[5]);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("overrun_sticky", fault_overrun, 1);
        run(tbl[6]);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("sector_sticky", fault_sector, 1);
        chk("sector_exit_gates", {gate_high, gate_low}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("faults_cleared", {fault_overrun, fault_sector}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
